// File: rtl/axi_pkg.sv
// Shared AXI4-Lite widths and response codes for the memory-side slaves.
package axi_pkg;

    localparam int AXI_ADDR_BITS = 32;
    localparam int AXI_DATA_BITS = 32;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

endpackage

// File: rtl/sram_1p.sv
// Single-port synchronous SRAM, one-cycle read latency, per-byte write enables.
// Built as independent byte lanes so it maps onto byte-wide block RAM or a macro.
module sram_1p #(
    parameter int WORDS     = 16384,
    parameter int DATA_BITS = 32,
    localparam int ADDR_BITS = $clog2(WORDS),
    localparam int BYTES     = DATA_BITS / 8
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic [BYTES-1:0]     we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_BITS-1:0] d,
    output logic [DATA_BITS-1:0] q
);

    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
        logic [7:0] mem [WORDS];
        logic [7:0] q_reg;

        // Read-first: a write in the same cycle returns the old byte.
        always_ff @(posedge clk) begin
            if (en) begin
                if (we[gi]) begin
                    mem[addr] <= d[gi*8 +: 8];
                end
                q_reg <= mem[addr];
            end
        end

        assign q[gi*8 +: 8] = q_reg;
    end

endmodule

// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite slave serving one transaction at a time out of a byte-writable SRAM.
// Reads and writes alternate priority on every grant so neither side starves.
module axi_lite_sram_slave
    import axi_pkg::*;
#(
    parameter logic [AXI_ADDR_BITS-1:0] BASE_ADDR = '0,
    parameter int                       MEM_WORDS = 16384
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic [AXI_ADDR_BITS-1:0]   ARADDR,
    input  logic                       ARVALID,
    output logic                       ARREADY,
    output logic [AXI_DATA_BITS-1:0]   RDATA,
    output logic [1:0]                 RRESP,
    output logic                       RVALID,
    input  logic                       RREADY,
    input  logic [AXI_ADDR_BITS-1:0]   AWADDR,
    input  logic                       AWVALID,
    output logic                       AWREADY,
    input  logic [AXI_DATA_BITS-1:0]   WDATA,
    input  logic [AXI_DATA_BITS/8-1:0] WSTRB,
    input  logic                       WVALID,
    output logic                       WREADY,
    output logic [1:0]                 BRESP,
    output logic                       BVALID,
    input  logic                       BREADY
);

    localparam int IDX_BITS  = $clog2(MEM_WORDS);
    localparam int STRB_BITS = AXI_DATA_BITS / 8;
    localparam logic [AXI_ADDR_BITS:0] SPAN = (AXI_ADDR_BITS+1)'(MEM_WORDS) << 2;

    typedef enum logic [1:0] {IDLE, RD_FETCH, RD_RESP, WR_RESP} state_t;
    typedef enum logic {PRIO_READ, PRIO_WRITE} prio_t;

    state_t state_reg, state_next;
    prio_t  prio_reg;
    logic   rd_err_reg;
    logic [AXI_DATA_BITS-1:0] rdata_reg;
    resp_t  rresp_reg, bresp_reg;

    logic ar_grant, aw_grant;
    logic ar_ok, aw_ok;
    logic [AXI_ADDR_BITS-1:0] ar_off, aw_off;
    logic [IDX_BITS-1:0] ar_idx, aw_idx;

    logic                  sram_en;
    logic [STRB_BITS-1:0]  sram_we;
    logic [IDX_BITS-1:0]   sram_addr;
    logic [AXI_DATA_BITS-1:0] sram_q;

    // Addresses below the base wrap to huge offsets, so only the span test is needed.
    assign ar_off = ARADDR - BASE_ADDR;
    assign aw_off = AWADDR - BASE_ADDR;
    assign ar_ok  = {1'b0, ar_off} < SPAN;
    assign aw_ok  = {1'b0, aw_off} < SPAN;
    assign ar_idx = ar_off[IDX_BITS+1:2];
    assign aw_idx = aw_off[IDX_BITS+1:2];

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (ar_grant) begin
                    state_next = RD_FETCH;
                end else if (aw_grant) begin
                    state_next = WR_RESP;
                end
            end
            RD_FETCH: state_next = RD_RESP;
            RD_RESP:  if (RREADY) state_next = IDLE;
            WR_RESP:  if (BREADY) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Grants double as READYs; held low while reset is asserted.
    always_comb begin
        ar_grant  = 1'b0;
        aw_grant  = 1'b0;
        if (state_reg == IDLE && ARESETn) begin
            if (ARVALID && (!(AWVALID && WVALID) || prio_reg == PRIO_READ)) begin
                ar_grant = 1'b1;
            end else if (AWVALID && WVALID) begin
                aw_grant = 1'b1;
            end
        end
        ARREADY   = ar_grant;
        AWREADY   = aw_grant;
        WREADY    = aw_grant;
        RVALID    = (state_reg == RD_RESP);
        BVALID    = (state_reg == WR_RESP);
        sram_en   = (ar_grant && ar_ok) || (aw_grant && aw_ok);
        sram_we   = (aw_grant && aw_ok) ? WSTRB : '0;
        sram_addr = aw_grant ? aw_idx : ar_idx;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            prio_reg   <= PRIO_READ;
            rd_err_reg <= 1'b0;
            rdata_reg  <= '0;
            rresp_reg  <= OKAY;
            bresp_reg  <= OKAY;
        end else begin
            if (ar_grant) begin
                prio_reg   <= PRIO_WRITE;
                rd_err_reg <= !ar_ok;
            end
            if (aw_grant) begin
                prio_reg  <= PRIO_READ;
                bresp_reg <= aw_ok ? OKAY : SLVERR;
            end
            if (state_reg == RD_FETCH) begin
                rdata_reg <= rd_err_reg ? '0 : sram_q;
                rresp_reg <= rd_err_reg ? SLVERR : OKAY;
            end
        end
    end

    assign RDATA = rdata_reg;
    assign RRESP = rresp_reg;
    assign BRESP = bresp_reg;

    sram_1p #(
        .WORDS     (MEM_WORDS),
        .DATA_BITS (AXI_DATA_BITS)
    ) u_sram (
        .clk  (ACLK),
        .en   (sram_en),
        .we   (sram_we),
        .addr (sram_addr),
        .d    (WDATA),
        .q    (sram_q)
    );

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Randomized bench for axi_lite_sram_slave against an array-based memory model.
module tb_axi_lite_sram_slave;
    import axi_pkg::*;

    localparam int          MW   = 16384;
    localparam logic [31:0] BASE = 32'h0;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [31:0] ARADDR = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY = 1'b0;
    logic [31:0] AWADDR = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;

    int total = 0;
    int bad   = 0;
    bit prio_m;                    // 0: read wins next tie, 1: write wins
    logic [31:0] mem_m [int];

    axi_lite_sram_slave #(.BASE_ADDR(BASE), .MEM_WORDS(MW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= BASE) && ((longint'(a) - longint'(BASE)) < longint'(4 * MW));
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [31:0] exp_data(input logic [31:0] a);
        if (!in_rng(a)) return 32'h0;
        return mem_m.exists(widx(a)) ? mem_m[widx(a)] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] exp_resp(input logic [31:0] a);
        return in_rng(a) ? 32'(OKAY) : 32'(SLVERR);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        if (in_rng(a)) begin
            w = mem_m.exists(widx(a)) ? mem_m[widx(a)] : 32'h0;
            for (int b = 0; b < 4; b++) if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
            mem_m[widx(a)] = w;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int stall);
        int n = 0;
        @(negedge ACLK);
        AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
        #1;
        while (!(AWREADY && WREADY) && n < 20) begin
            @(negedge ACLK); #1; n++;
        end
        chk("wr_grant", 32'({AWREADY, WREADY}), 32'h3);
        @(posedge ACLK);
        model_write(a, d, s);
        prio_m = 1'b0;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
        #1;
        chk("wr_bvalid_t1", 32'(BVALID), 32'h1);
        chk("wr_bresp", 32'(BRESP), exp_resp(a));
        for (int i = 0; i < stall; i++) begin
            @(negedge ACLK); #1;
            chk("wr_stall_bvalid", 32'(BVALID), 32'h1);
        end
        BREADY = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        BREADY = 1'b0;
        #1;
        chk("wr_bvalid_drop", 32'(BVALID), 32'h0);
        $display("write addr=%h data=%h strb=%h bresp=%0d", a, d, s, BRESP);
    endtask

    task automatic rd(input logic [31:0] a, input int stall, output logic [31:0] got);
        int n = 0;
        logic [31:0] ed;
        @(negedge ACLK);
        ARADDR = a; ARVALID = 1'b1; RREADY = 1'b0;
        #1;
        while (!ARREADY && n < 20) begin
            @(negedge ACLK); #1; n++;
        end
        chk("rd_grant", 32'(ARREADY), 32'h1);
        @(posedge ACLK);
        prio_m = 1'b1;
        ed = exp_data(a);
        @(negedge ACLK);
        ARVALID = 1'b0;
        #1;
        chk("rd_rvalid_t1", 32'(RVALID), 32'h0);
        @(negedge ACLK); #1;
        chk("rd_rvalid_t2", 32'(RVALID), 32'h1);
        chk("rd_rdata", RDATA, ed);
        chk("rd_rresp", 32'(RRESP), exp_resp(a));
        got = RDATA;
        ARVALID = (stall > 0);
        for (int i = 0; i < stall; i++) begin
            @(negedge ACLK); #1;
            chk("rd_stall_rvalid", 32'(RVALID), 32'h1);
            chk("rd_stall_rdata", RDATA, ed);
            chk("rd_stall_arready", 32'(ARREADY), 32'h0);
        end
        ARVALID = 1'b0;
        RREADY = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        RREADY = 1'b0;
        #1;
        chk("rd_rvalid_drop", 32'(RVALID), 32'h0);
        $display("read  addr=%h data=%h rresp=%0d", a, got, RRESP);
    endtask

    initial begin
        logic [31:0] rdv;
        logic [31:0] a;
        int grants;
        int cyc;

        // Reset with every VALID asserted: nothing may leak out.
        ARESETn = 1'b0;
        ARADDR = 4 * MW; AWADDR = 32'h14; WDATA = 32'h5A5A_0001; WSTRB = 4'hF;
        ARVALID = 1'b1; AWVALID = 1'b1; WVALID = 1'b1; RREADY = 1'b1; BREADY = 1'b1;
        repeat (3) @(negedge ACLK);
        #1;
        chk("rst_ready_valid", 32'({ARREADY, AWREADY, WREADY, RVALID, BVALID}), 32'h0);
        chk("rst_rdata", RDATA, 32'h0);
        chk("rst_resp", 32'({RRESP, BRESP}), 32'h0);
        prio_m = 1'b0;
        @(negedge ACLK);
        ARESETn = 1'b1;

        // Contention: both sides valid every cycle, grants must alternate starting with read.
        grants = 0;
        cyc = 0;
        while (grants < 4 && cyc < 60) begin
            #1;
            cyc++;
            if (RVALID) begin
                chk("cont_rdata_oor", RDATA, 32'h0);
                chk("cont_rresp_oor", 32'(RRESP), 32'(SLVERR));
            end
            if (RVALID || BVALID)
                chk("cont_busy_ready", 32'({ARREADY, AWREADY}), 32'h0);
            if (ARREADY || AWREADY) begin
                chk("cont_order", 32'({AWREADY, ARREADY}), prio_m ? 32'h2 : 32'h1);
                $display("grant %0d %s", grants, AWREADY ? "W" : "R");
                if (AWREADY) begin
                    model_write(AWADDR, WDATA, WSTRB);
                    prio_m = 1'b0;
                end else begin
                    prio_m = 1'b1;
                end
                grants++;
                if (grants == 4) @(posedge ACLK);
            end
            @(negedge ACLK);
        end
        chk("cont_grants", 32'(grants), 32'h4);
        ARVALID = 1'b0; AWVALID = 1'b0; WVALID = 1'b0;
        repeat (3) @(negedge ACLK);
        RREADY = 1'b0; BREADY = 1'b0;

        // Directed: write/readback, byte strobes, zero strobe, out of range, back-pressure.
        rd(32'h14, 0, rdv);
        wr(32'h10, 32'hDEAD_BEEF, 4'hF, 0);
        rd(32'h10, 0, rdv);
        wr(32'h20, 32'h1122_3344, 4'hF, 0);
        wr(32'h20, 32'hAABB_CCDD, 4'b0101, 2);
        rd(32'h20, 5, rdv);
        chk("strobe_merge", rdv, 32'h11BB_33DD);
        wr(32'h10, 32'h0BAD_F00D, 4'h0, 0);
        rd(32'h13, 0, rdv);
        rd(4 * MW, 0, rdv);
        wr(4 * MW + 32'h40, 32'hFFFF_FFFF, 4'hF, 1);

        // Random traffic over a 16-word window plus occasional out-of-range hits.
        for (int w = 0; w < 16; w++) wr(32'(w * 4), $urandom, 4'hF, 0);
        for (int i = 0; i < 40; i++) begin
            a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = 4 * MW + 32'($urandom_range(0, 255) * 4);
            if ($urandom_range(0, 1) == 1)
                wr(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
            else
                rd(a, $urandom_range(0, 3), rdv);
        end

        // AW alone is never accepted; W completes the pair; reset kills the pending B.
        @(negedge ACLK);
        AWADDR = 32'h30; WDATA = 32'hCAFE_F00D; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b0; BREADY = 1'b0;
        repeat (3) begin
            #1;
            chk("aw_only_ready", 32'({AWREADY, WREADY}), 32'h0);
            @(negedge ACLK);
        end
        WVALID = 1'b1;
        #1;
        chk("aw_w_ready", 32'({AWREADY, WREADY}), 32'h3);
        @(posedge ACLK);
        model_write(32'h30, 32'hCAFE_F00D, 4'hF);
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
        #1;
        chk("aw_w_bvalid", 32'(BVALID), 32'h1);
        ARESETn = 1'b0;
        #1;
        chk("rst_bvalid_drop", 32'(BVALID), 32'h0);
        prio_m = 1'b0;
        @(negedge ACLK);
        ARESETn = 1'b1;
        rd(32'h30, 0, rdv);
        chk("committed_write", rdv, 32'hCAFE_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
